// File: rtl/proc_pkg.sv
// proc_pkg: shared definitions for the multi-cycle IRMOV-family core.
//   - icode / ifun constants
//   - FSM state encoding (also exported on the core's state port)
//   - imm_width(): immediate field width left after the three register fields
package proc_pkg;

    localparam logic [3:0] ICODE_NOP   = 4'h0;
    localparam logic [3:0] ICODE_IRMOV = 4'h1;
    localparam logic [3:0] ICODE_RRMOV = 4'h2;
    localparam logic [3:0] ICODE_OP    = 4'h3;
    localparam logic [3:0] ICODE_HALT  = 4'hF;

    localparam logic [3:0] IFUN_ADD = 4'h0;
    localparam logic [3:0] IFUN_SUB = 4'h1;
    localparam logic [3:0] IFUN_AND = 4'h2;
    localparam logic [3:0] IFUN_OR  = 4'h3;
    localparam logic [3:0] IFUN_XOR = 4'h4;
    localparam logic [3:0] IFUN_SHL = 4'h5;
    localparam logic [3:0] IFUN_SHR = 4'h6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Bits [23:0] carry rA, rB, rd and then the immediate.
    function automatic int unsigned imm_width(input int unsigned reg_aw);
        return 24 - 3 * reg_aw;
    endfunction

endpackage

// File: rtl/proc_multicycle_if.sv
// proc_multicycle_if: program-load bus of the multi-cycle core.
//   addr   program RAM word address
//   wr     write enable (the core honours it only while not working)
//   wdata  32-bit instruction word
// master drives the bus (loader / bench), slave is the core.
interface proc_multicycle_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [31:0]       wdata;

    modport master (output addr, output wr, output wdata);
    modport slave  (input  addr, input  wr, input  wdata);
endinterface

// File: rtl/proc_alu.sv
// proc_alu: combinational register-register ALU.
//   ifun   in  4       operation select (add, sub, and, or, xor, shl, shr)
//   a, b   in  DATA_W  operands; shifts use b[log2(DATA_W)-1:0] as the amount
//   y      out DATA_W  result, wraps modulo 2**DATA_W
//   valid  out 1       low for unassigned ifun codes, which must not write back
module proc_alu
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              valid
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;

    assign sh = b[SH_W-1:0];

    always_comb begin
        y     = '0;
        valid = 1'b1;
        case (ifun)
            IFUN_ADD: y = a + b;
            IFUN_SUB: y = a - b;
            IFUN_AND: y = a & b;
            IFUN_OR:  y = a | b;
            IFUN_XOR: y = a ^ b;
            IFUN_SHL: y = a << sh;
            IFUN_SHR: y = a >> sh;
            default:  valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_multicycle.sv
// proc_multicycle: multi-cycle execution core with program RAM and register file.
// Program is loaded through the load bus while working=0, then each instruction
// runs FETCH -> DECODE -> EXEC -> WB (4 cycles).
// Optional feature macro: PROC_HALT_EN (icode 0xF halts the core until reset).
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high
//   load       slave modport of proc_multicycle_if (addr / wr / wdata)
//   working    in   run enable; dropping it parks the core after the current WB
//   regs_flat  out  register file, reg i at [i*DATA_W +: DATA_W]
//   pc         out  address of the instruction being fetched or executed
//   state      out  FSM state (proc_pkg::state_t encoding)
//   icode      out  latched instr[31:28]
//   ifun       out  latched instr[27:24]
//   busy       out  high in every state except IDLE and HALT
//   halted     out  high in HALT (never set without PROC_HALT_EN)
module proc_multicycle
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                             clock,
    input  logic                             reset,
    proc_multicycle_if.slave                 load,
    input  logic                             working,
    output logic [(2**REG_AW)*DATA_W-1:0]    regs_flat,
    output logic [ADDR_W-1:0]                pc,
    output logic [2:0]                       state,
    output logic [3:0]                       icode,
    output logic [3:0]                       ifun,
    output logic                             busy,
    output logic                             halted
);

    localparam int unsigned NREG  = 2**REG_AW;
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned IMM_W = imm_width(REG_AW);

`ifdef PROC_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_t            state_q;
    logic [31:0]       ram [DEPTH];
    logic [31:0]       ram_q;
    logic [31:0]       instr_q;
    logic [DATA_W-1:0] rf [NREG];
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] res_q;
    logic              res_we_q;

    logic [REG_AW-1:0] dec_ra;
    logic [REG_AW-1:0] dec_rb;
    logic [REG_AW-1:0] wb_rd;
    logic [IMM_W-1:0]  ex_imm;
    logic [DATA_W-1:0] alu_y;
    logic              alu_valid;
    logic [DATA_W-1:0] exec_res;
    logic              exec_we;
    logic              halt_op;

    // Source fields come straight from the RAM output in DECODE; rd and imm
    // come from the latched instruction.
    assign dec_ra = ram_q[23 -: REG_AW];
    assign dec_rb = ram_q[23-REG_AW -: REG_AW];
    assign wb_rd  = instr_q[23-2*REG_AW -: REG_AW];
    assign ex_imm = instr_q[IMM_W-1:0];

    assign icode   = instr_q[31:28];
    assign ifun    = instr_q[27:24];
    assign state   = state_q;
    assign halt_op = HALT_EN && (instr_q[31:28] == ICODE_HALT);

    // Program RAM: writes only while not working, synchronous read of pc in FETCH.
    always_ff @(posedge clock) begin
        if (!working && load.wr) begin
            ram[load.addr] <= load.wdata;
        end
        if (state_q == S_FETCH) begin
            ram_q <= ram[pc];
        end
    end

    proc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .ifun  (instr_q[27:24]),
        .a     (opa_q),
        .b     (opb_q),
        .y     (alu_y),
        .valid (alu_valid)
    );

    always_comb begin
        exec_res = '0;
        exec_we  = 1'b0;
        case (instr_q[31:28])
            ICODE_IRMOV: begin
                exec_res = DATA_W'(ex_imm);
                exec_we  = 1'b1;
            end
            ICODE_RRMOV: begin
                exec_res = opa_q;
                exec_we  = 1'b1;
            end
            ICODE_OP: begin
                exec_res = alu_y;
                exec_we  = alu_valid;
            end
            default: begin
                exec_res = '0;
                exec_we  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc       <= '0;
            instr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            res_q    <= '0;
            res_we_q <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (working) begin
                        state_q <= S_FETCH;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    instr_q <= ram_q;
                    opa_q   <= rf[dec_ra];
                    opb_q   <= rf[dec_rb];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    res_q    <= exec_res;
                    res_we_q <= exec_we;
                    state_q  <= S_WB;
                end
                S_WB: begin
                    if (res_we_q) begin
                        rf[wb_rd] <= res_q;
                    end
                    // A halting instruction keeps pc on itself.
                    if (halt_op) begin
                        state_q <= S_HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        pc      <= pc + 1'b1;
                        state_q <= working ? S_FETCH : S_IDLE;
                        busy    <= working;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = rf[i];
        end
    end

endmodule

// File: tb/tb_proc_multicycle.sv
// Self-checking bench for proc_multicycle (DATA_W=32, REG_AW=3, ADDR_W=9).
// An instruction-level model retires one instruction each time the core leaves
// WB and is compared with pc/halted/busy and all registers on every negedge;
// directed phases add hand-computed literal expectations.
module tb_proc_multicycle;
    import proc_pkg::*;

    logic         clock;
    logic         reset;
    logic         working;
    logic [255:0] regs_flat;
    logic [8:0]   pc;
    logic [2:0]   dut_state;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic         busy;
    logic         halted;

    int n_checks = 0;
    int n_fail   = 0;

    proc_multicycle_if #(.ADDR_W(9)) lb();

    proc_multicycle #(
        .DATA_W (32),
        .REG_AW (3),
        .ADDR_W (9)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (lb),
        .working   (working),
        .regs_flat (regs_flat),
        .pc        (pc),
        .state     (dut_state),
        .icode     (icode),
        .ifun      (ifun),
        .busy      (busy),
        .halted    (halted)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    logic [31:0] mmem [512];
    logic [31:0] mregs [8];
    logic [8:0]  mpc;
    logic        mhalted;

    function automatic logic [31:0] rget(input int i);
        return regs_flat[i*32 +: 32];
    endfunction

    function automatic logic [31:0] enc(input logic [3:0] ic, input logic [3:0] fn,
                                        input logic [2:0] ra, input logic [2:0] rb,
                                        input logic [2:0] rd, input logic [14:0] imm);
        return {ic, fn, ra, rb, rd, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
        mpc     = 9'd0;
        mhalted = 1'b0;
    endtask

    task automatic model_retire();
        logic [31:0] ins, a, b, r;
        logic [3:0]  ic, fn;
        logic [2:0]  rd;
        bit          wr_en;
        ins   = mmem[mpc];
        ic    = ins[31:28];
        fn    = ins[27:24];
        rd    = ins[17:15];
        a     = mregs[ins[23:21]];
        b     = mregs[ins[20:18]];
        r     = 32'h0;
        wr_en = 1'b0;
        if (ic == 4'd1) begin
            r = {17'd0, ins[14:0]}; wr_en = 1'b1;
        end else if (ic == 4'd2) begin
            r = a; wr_en = 1'b1;
        end else if (ic == 4'd3 && fn <= 4'd6) begin
            wr_en = 1'b1;
            case (fn)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: r = a << b[4:0];
                default: r = a >> b[4:0];
            endcase
        end
        if (wr_en) mregs[rd] = r;
`ifdef PROC_HALT_EN
        if (ic == 4'hF) mhalted = 1'b1;
        else mpc = mpc + 9'd1;
`else
        mpc = mpc + 9'd1;
`endif
    endtask

    // Compare process: one model step per WB exit, full compare each negedge.
    initial begin
        logic [2:0] prev;
        prev = 3'd0;
        model_reset();
        forever begin
            @(negedge clock or posedge reset);
            if (reset) begin
                model_reset();
                prev = 3'd0;
            end else begin
                if (prev == S_WB) model_retire();
                prev = dut_state;
                check("pc", 32'(pc), 32'(mpc));
                check("halted", 32'(halted), 32'(mhalted));
                check("busy", 32'(busy), 32'(dut_state != S_IDLE && dut_state != S_HALT));
                for (int i = 0; i < 8; i++) begin
                    check($sformatf("r%0d", i), rget(i), mregs[i]);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int a, input logic [31:0] d);
        @(negedge clock);
        lb.addr  = 9'(a);
        lb.wdata = d;
        lb.wr    = 1'b1;
        if (!working) mmem[a] = d;
    endtask

    task automatic load_done();
        @(negedge clock);
        lb.wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        working = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_for(input logic [2:0] st, input int p, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (dut_state == st && (p < 0 || int'(pc) == p)) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, state=%0d pc=%0d, required state=%0d pc=%0d",
                     name, budget, dut_state, pc, st, p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset    = 1'b1;
        working  = 1'b0;
        lb.addr  = '0;
        lb.wr    = 1'b0;
        lb.wdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_state", 32'(dut_state), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_icode", 32'({icode, ifun}), 32'd0);

        // Program: T1 at @0, T2 arithmetic, every ALU op, RRMOV, rd=rA, NOP-like codes.
        load(0,  32'h1000_8005);
        load(1,  enc(4'h1, 4'h0, 3'd0, 3'd0, 3'd1, 15'd7));
        load(2,  enc(4'h1, 4'h0, 3'd0, 3'd0, 3'd2, 15'd3));
        load(3,  enc(4'h3, 4'h1, 3'd1, 3'd2, 3'd3, 15'd0));
        load(4,  enc(4'h3, 4'h1, 3'd2, 3'd1, 3'd4, 15'd0));
        load(5,  enc(4'h3, 4'h0, 3'd4, 3'd1, 3'd5, 15'd0));
        load(6,  enc(4'h3, 4'h2, 3'd1, 3'd2, 3'd6, 15'd0));
        load(7,  enc(4'h3, 4'h3, 3'd1, 3'd4, 3'd7, 15'd0));
        load(8,  enc(4'h3, 4'h4, 3'd4, 3'd2, 3'd0, 15'd0));
        load(9,  enc(4'h3, 4'h5, 3'd1, 3'd2, 3'd6, 15'd0));
        load(10, enc(4'h3, 4'h6, 3'd4, 3'd2, 3'd7, 15'd0));
        load(11, enc(4'h2, 4'h0, 3'd1, 3'd0, 3'd2, 15'd0));
        load(12, enc(4'h3, 4'h0, 3'd1, 3'd1, 3'd1, 15'd0));
        load(13, enc(4'h3, 4'h7, 3'd1, 3'd1, 3'd3, 15'd0));
        load(14, enc(4'h5, 4'h0, 3'd0, 3'd0, 3'd3, 15'h7FFF));
`ifdef PROC_HALT_EN
        load(15, enc(4'hE, 4'h0, 3'd0, 3'd0, 3'd3, 15'h1234));
`else
        load(15, enc(4'hF, 4'h0, 3'd0, 3'd0, 3'd3, 15'h1234));
`endif
        for (int a = 16; a < 20; a++) load(a, 32'h0);
        load_done();

        // T1: first instruction retires on the 5th edge after working rises.
        working = 1'b1;
        repeat (4) @(negedge clock);
        check("t1_state_wb", 32'(dut_state), 32'd4);
        check("t1_r1_before", rget(1), 32'd0);
        @(negedge clock);
        check("t1_r1", rget(1), 32'd5);
        check("t1_pc", 32'(pc), 32'd1);
        check("t1_state_fetch", 32'(dut_state), 32'd1);

        // T3: drop working in EXEC of instruction 2.
        wait_for(S_EXEC, 2, 20, "t3_exec2");
        working = 1'b0;
        wait_for(S_IDLE, -1, 5, "t3_idle");
        check("t3_pc", 32'(pc), 32'd3);
        check("t3_r2", rget(2), 32'd3);
        repeat (3) @(negedge clock);
        check("t3_parked_pc", 32'(pc), 32'd3);
        working = 1'b1;
        wait_for(S_EXEC, 3, 10, "t3_exec3");
        check("t3_icode", 32'(icode), 32'd3);
        check("t3_ifun", 32'(ifun), 32'd1);

        wait_for(S_FETCH, 17, 100, "t2_run");
        working = 1'b0;
        wait_for(S_IDLE, -1, 10, "t2_idle");
        check("t2_r0_xor", rget(0), 32'hFFFF_FFFF);
        check("t2_r1_add_self", rget(1), 32'd14);
        check("t2_r2_rrmov", rget(2), 32'd7);
        check("t2_r3_sub", rget(3), 32'd4);
        check("t2_r4_sub_neg", rget(4), 32'hFFFF_FFFC);
        check("t2_r5_add_wrap", rget(5), 32'd3);
        check("t2_r6_shl", rget(6), 32'h0000_0038);
        check("t2_r7_shr", rget(7), 32'h1FFF_FFFF);

        // T4: fill the rest with NOPs, attempt a write while running, run past 511.
        do_reset();
        for (int a = 20; a < 512; a++) load(a, 32'h0);
        load_done();
        working = 1'b1;
        load(300, enc(4'h1, 4'h0, 3'd0, 3'd0, 3'd6, 15'h1234));
        load_done();
        wait_for(S_FETCH, 511, 2300, "t4_pc511");
        wait_for(S_FETCH, 0, 8, "t4_wrap");
        check("t4_pc_wrapped", 32'(pc), 32'd0);
        check("t4_r6_unchanged", rget(6), 32'h0000_0038);
        working = 1'b0;
        wait_for(S_IDLE, -1, 10, "t4_idle");

        // T5: asynchronous reset in the middle of EXEC.
        working = 1'b1;
        wait_for(S_EXEC, -1, 10, "t5_exec");
        #2;
        reset = 1'b1;
        #1;
        check("t5_state", 32'(dut_state), 32'd0);
        check("t5_pc", 32'(pc), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_icode", 32'({icode, ifun}), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("t5_r%0d", i), rget(i), 32'd0);
        working = 1'b0;
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_still_idle", 32'(dut_state), 32'd0);

`ifdef PROC_HALT_EN
        // T6: HALT at @2 freezes the core.
        do_reset();
        load(0, enc(4'h1, 4'h0, 3'd0, 3'd0, 3'd1, 15'd9));
        load(1, 32'h0);
        load(2, 32'hF000_0000);
        load(3, enc(4'h1, 4'h0, 3'd0, 3'd0, 3'd1, 15'h77));
        load_done();
        working = 1'b1;
        wait_for(S_HALT, 2, 30, "t6_halt");
        check("t6_pc", 32'(pc), 32'd2);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_halted", 32'(halted), 32'd1);
        repeat (20) @(negedge clock);
        check("t6_r1_frozen", rget(1), 32'd9);
        check("t6_pc_frozen", 32'(pc), 32'd2);
        check("t6_state_frozen", 32'(dut_state), 32'd5);
        working = 1'b0;
        do_reset();
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
